// File: rtl/register_file_pkg.sv
// Shared types and parameter-legality helpers for the latch-based register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package register_file_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    function automatic bit rf_is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit rf_byte_aligned(input int unsigned w);
        return (w != 0) && ((w % 8) == 0);
    endfunction

    // Wide word must split into a power-of-two number of whole narrow slices.
    function automatic bit rf_ratio_ok(input int unsigned wdw, input int unsigned rdw);
        if (rdw == 0) return 1'b0;
        if ((wdw % rdw) != 0) return 1'b0;
        return rf_is_pow2(wdw / rdw);
    endfunction

endpackage

// File: rtl/register_file_latch_word.sv
// One wide storage word: a clock gate and an 8-bit latch per byte lane.
// Latency: byte becomes transparent in the high phase after the write edge.
// Backpressure: none; enables are qualified by the parent.
module register_file_latch_word #(
    parameter int unsigned WDATA_WIDTH = 128
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [WDATA_WIDTH/8-1:0] be_i,
    input  logic [WDATA_WIDTH-1:0]   wdata_i,
    output logic [WDATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned BE_WIDTH = WDATA_WIDTH / 8;

    for (genvar b = 0; b < BE_WIDTH; b++) begin : g_byte
        logic       byte_clk;
        logic [7:0] byte_q;

        tc_clk_gating u_cg (
            .clk_i     (clk_i),
            .en_i      (we_i & be_i[b]),
            .test_en_i (1'b0),
            .clk_o     (byte_clk)
        );

        always_latch begin
            if (byte_clk) byte_q <= wdata_i[8*b +: 8];
        end

        assign rdata_o[8*b +: 8] = byte_q;
    end

endmodule

// File: rtl/tc_clk_gating.sv
// Glitch-free clock gate: enable captured while the clock is low, ANDed with the clock.
// Latency: gated pulse appears in the high phase following the edge the enable was set up for.
// Backpressure: none.
module tc_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic clk_en;

    always_latch begin
        if (!clk_i) clk_en <= en_i | test_en_i;
    end

    assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/register_file_1w_be_multi_port_read.sv
// Latch register file: one wide byte-enabled write port, N_READ narrow read ports, optional clear.
// Latency: write visible on ReadData before the next edge; read address captured at edge, data before next edge.
// Backpressure: WriteReady low during the post-reset clear; writes issued then are dropped.
module register_file_1w_be_multi_port_read
    import register_file_pkg::*;
#(
    parameter  int unsigned WADDR_WIDTH    = 5,
    parameter  int unsigned WDATA_WIDTH    = 128,
    parameter  int unsigned RDATA_WIDTH    = 32,
    parameter  int unsigned N_READ         = 4,
    parameter  bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned RATIO          = WDATA_WIDTH / RDATA_WIDTH,
    localparam int unsigned RADDR_WIDTH    = WADDR_WIDTH + $clog2(RATIO),
    localparam int unsigned BE_WIDTH       = WDATA_WIDTH / 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [N_READ-1:0]                      ReadEnable,
    input  logic [N_READ-1:0][RADDR_WIDTH-1:0]     ReadAddr,
    output logic [N_READ-1:0][RDATA_WIDTH-1:0]     ReadData,
    input  logic                                   WriteEnable,
    input  logic [WADDR_WIDTH-1:0]                 WriteAddr,
    input  logic [WDATA_WIDTH-1:0]                 WriteData,
    input  logic [BE_WIDTH-1:0]                    WriteBE,
    output logic                                   WriteReady,
    output logic                                   InitDone
);

    localparam int unsigned NUM_W_WORDS = 2 ** WADDR_WIDTH;
    localparam int unsigned RATIO_LOG2  = $clog2(RATIO);
    localparam rf_state_e   RESET_STATE = CLEAR_ON_RESET ? RF_CLEAR : RF_READY;

    if (!rf_byte_aligned(RDATA_WIDTH)) begin : g_bad_rdata_width
        $error("RDATA_WIDTH must be a non-zero multiple of 8");
    end
    if (!rf_ratio_ok(WDATA_WIDTH, RDATA_WIDTH)) begin : g_bad_ratio
        $error("WDATA_WIDTH/RDATA_WIDTH must be an integer power of two");
    end
    if (N_READ < 1) begin : g_bad_nread
        $error("N_READ must be at least 1");
    end

    rf_state_e                                        state_q, state_d;
    logic [WADDR_WIDTH-1:0]                           clr_idx_q, clr_idx_d;
    logic                                             clearing;
    logic                                             wr_accept;
    logic                                             wr_clk;
    logic [WDATA_WIDTH-1:0]                           wdata_q;
    logic [BE_WIDTH-1:0]                              wr_be;
    logic [N_READ-1:0][RADDR_WIDTH-1:0]               raddr_q;
    logic [NUM_W_WORDS-1:0][RATIO-1:0][RDATA_WIDTH-1:0] mem_rdata;

    assign clearing   = (state_q == RF_CLEAR);
    assign WriteReady = (state_q == RF_READY);
    assign InitDone   = WriteReady;
    assign wr_accept  = WriteEnable & WriteReady;
    assign wr_be      = clearing ? '1 : WriteBE;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (clearing) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == WADDR_WIDTH'(NUM_W_WORDS - 1)) state_d = RF_READY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Write data flops only toggle on cycles that actually update the array.
    tc_clk_gating u_wr_cg (
        .clk_i     (clk),
        .en_i      (wr_accept | clearing),
        .test_en_i (1'b0),
        .clk_o     (wr_clk)
    );

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) wdata_q <= '0;
        else        wdata_q <= clearing ? '0 : WriteData;
    end

    for (genvar w = 0; w < NUM_W_WORDS; w++) begin : g_word
        logic word_we;

        assign word_we = (wr_accept && (WriteAddr == WADDR_WIDTH'(w)))
                      || (clearing  && (clr_idx_q == WADDR_WIDTH'(w)));

        register_file_latch_word #(
            .WDATA_WIDTH (WDATA_WIDTH)
        ) u_word (
            .clk_i   (clk),
            .we_i    (word_we),
            .be_i    (wr_be),
            .wdata_i (wdata_q),
            .rdata_o (mem_rdata[w])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q <= '0;
        end else begin
            for (int z = 0; z < N_READ; z++) begin
                if (ReadEnable[z]) raddr_q[z] <= ReadAddr[z];
            end
        end
    end

    // Upper address bits pick the wide word, lower bits the slice (slice 0 = LSBs).
    for (genvar z = 0; z < N_READ; z++) begin : g_rport
        logic [WADDR_WIDTH-1:0] rword;
        assign rword = raddr_q[z][RADDR_WIDTH-1 -: WADDR_WIDTH];
        if (RATIO_LOG2 > 0) begin : g_sliced
            assign ReadData[z] = mem_rdata[rword][raddr_q[z][RATIO_LOG2-1:0]];
        end else begin : g_whole
            assign ReadData[z] = mem_rdata[rword][0];
        end
    end

endmodule

// File: tb/tb_register_file_1w_be_multi_port_read.sv
// Directed bench: clear sequence, byte-enable writes, write-through, multi-port reads, reset corners.
module tb_register_file_1w_be_multi_port_read;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       ReadEnable;
    logic [3:0][6:0]  ReadAddr;
    logic [3:0][31:0] ReadData;
    logic             WriteEnable;
    logic [4:0]       WriteAddr;
    logic [127:0]     WriteData;
    logic [15:0]      WriteBE;
    logic             WriteReady;
    logic             InitDone;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    register_file_1w_be_multi_port_read #(
        .WADDR_WIDTH    (5),
        .WDATA_WIDTH    (128),
        .RDATA_WIDTH    (32),
        .N_READ         (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ReadEnable  (ReadEnable),
        .ReadAddr    (ReadAddr),
        .ReadData    (ReadData),
        .WriteEnable (WriteEnable),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData),
        .WriteBE     (WriteBE),
        .WriteReady  (WriteReady),
        .InitDone    (InitDone)
    );

    typedef struct {
        logic             we;
        logic [4:0]       wa;
        logic [127:0]     wd;
        logic [15:0]      be;
        logic [3:0]       ren;
        logic [3:0][6:0]  ra;
        logic [3:0][31:0] ex;
        logic [3:0]       chk;
    } vec_t;

    vec_t vt [13];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [127:0] wd,
                                input logic [15:0] be, input logic [3:0] ren, input logic [27:0] ra,
                                input logic [127:0] ex, input logic [3:0] chk);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.be = be;
        v.ren = ren; v.ra = ra; v.ex = ex; v.chk = chk;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WriteEnable = 1'b0;
        WriteAddr   = '0;
        WriteData   = '0;
        WriteBE     = '0;
        ReadEnable  = '0;
    endtask

    // Counts edges until InitDone, starting from edges already elapsed since release.
    task automatic wait_init(input string name, input int start);
        int n;
        n = start;
        while (InitDone !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check(name, n, 32);
    endtask

    task automatic read4(input string name, input logic [27:0] ra, input logic [127:0] ex);
        logic [3:0][6:0]  a;
        logic [3:0][31:0] e;
        a = ra;
        e = ex;
        ReadEnable = 4'hF;
        ReadAddr   = a;
        step();
        for (int p = 0; p < 4; p++) check($sformatf("%s_p%0d", name, p), ReadData[p], e[p]);
        ReadEnable = 4'h0;
    endtask

    localparam logic [127:0] DA   = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] D5   = {32'h53530003, 32'h52520002, 32'h51510001, 32'hCAFE0005};
    localparam logic [127:0] D1   = {32'h44443333, 32'h33332222, 32'h22221111, 32'h11110000};
    localparam logic [127:0] D2   = {32'hBEEF0203, 32'hBEEF0202, 32'hBEEF0201, 32'hBEEF0200};
    localparam logic [127:0] D6   = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    localparam logic [127:0] C5   = {4{32'hCAFE0005}};

    initial begin
        // {we, word, data, BE, ren, {ra3..ra0}, {exp3..exp0}, check mask}
        vt[0]  = mk(1, 3, DA,   16'hFFFF, 4'hF, {7'd15, 7'd14, 7'd13, 7'd12},
                    {32'h01234567, 32'h89ABCDEF, 32'h01234567, 32'h89ABCDEF}, 4'hF);
        vt[1]  = mk(1, 3, ONES, 16'h000F, 4'hF, {7'd15, 7'd14, 7'd13, 7'd12},
                    {32'h01234567, 32'h89ABCDEF, 32'h01234567, 32'hFFFFFFFF}, 4'hF);
        vt[2]  = mk(1, 5, D5,   16'hFFFF, 4'hF, {7'd20, 7'd20, 7'd20, 7'd20}, C5, 4'hF);
        vt[3]  = mk(1, 1, D1,   16'hFFFF, 4'h0, 28'd0, C5, 4'hF);
        vt[4]  = mk(0, 0, 0,    16'h0000, 4'hF, {7'd7, 7'd6, 7'd5, 7'd4}, D1, 4'hF);
        vt[5]  = mk(0, 0, 0,    16'h0000, 4'b0101, {7'd0, 7'd21, 7'd0, 7'd20},
                    {32'h44443333, 32'h51510001, 32'h22221111, 32'hCAFE0005}, 4'hF);
        vt[6]  = mk(1, 1, 0,    16'h0000, 4'hF, {7'd7, 7'd6, 7'd5, 7'd4}, D1, 4'hF);
        vt[7]  = mk(1, 2, D2,   16'hFFFF, 4'h0, 28'd0, D1, 4'hF);
        vt[8]  = mk(1, 2, {16{8'h77}}, 16'h00F0, 4'hF, {7'd11, 7'd10, 7'd9, 7'd8},
                    {32'hBEEF0203, 32'hBEEF0202, 32'h77777777, 32'hBEEF0200}, 4'hF);
        vt[9]  = mk(0, 0, 0,    16'h0000, 4'hF, {7'd11, 7'd10, 7'd9, 7'd8},
                    {32'hBEEF0203, 32'hBEEF0202, 32'h77777777, 32'hBEEF0200}, 4'hF);
        vt[10] = mk(1, 6, D6,   16'hFFFF, 4'h0, 28'd0, 0, 4'h0);
        vt[11] = mk(1, 6, ONES, 16'h4421, 4'hF, {7'd27, 7'd26, 7'd25, 7'd24},
                    {32'hFFFFDDCC, 32'hBBFF9988, 32'h7766FF44, 32'h332211FF}, 4'hF);
        vt[12] = mk(0, 0, 0,    16'h0000, 4'hF, {7'd20, 7'd12, 7'd8, 7'd4},
                    {32'hCAFE0005, 32'hFFFFFFFF, 32'hBEEF0200, 32'h11110000}, 4'hF);

        idle();
        ReadAddr = '0;
        rst_n    = 1'b0;
        repeat (3) step();
        check("reset_initdone", {31'b0, InitDone}, 32'd0);
        check("reset_wrready", {31'b0, WriteReady}, 32'd0);
        rst_n = 1'b1;
        wait_init("clear_latency", 0);
        check("ready_after_clear", {31'b0, WriteReady}, 32'd1);

        for (int i = 0; i < 32; i++) begin
            ReadEnable = 4'hF;
            for (int p = 0; p < 4; p++) ReadAddr[p] = 7'(4 * i + p);
            step();
            for (int p = 0; p < 4; p++)
                check($sformatf("clear_rd%0d", 4 * i + p), ReadData[p], 32'd0);
        end
        idle();

        for (int i = 0; i < 13; i++) begin
            WriteEnable = vt[i].we;
            WriteAddr   = vt[i].wa;
            WriteData   = vt[i].wd;
            WriteBE     = vt[i].be;
            ReadEnable  = vt[i].ren;
            ReadAddr    = vt[i].ra;
            step();
            for (int p = 0; p < 4; p++)
                if (vt[i].chk[p]) check($sformatf("vec%0d_p%0d", i, p), ReadData[p], vt[i].ex[p]);
        end
        idle();

        // Write attempted during clear, to a word already cleared: must be dropped.
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        WriteEnable = 1'b1;
        WriteAddr   = 5'd1;
        WriteData   = ONES;
        WriteBE     = 16'hFFFF;
        check("clr_wrready", {31'b0, WriteReady}, 32'd0);
        step();
        idle();
        wait_init("clr_wr_latency", 3);
        read4("clr_wr_word1", {7'd7, 7'd6, 7'd5, 7'd4}, 128'd0);

        // Reset in the middle of the clear restarts it from word 0.
        WriteEnable = 1'b1;
        WriteAddr   = 5'd20;
        WriteData   = ONES;
        WriteBE     = 16'hFFFF;
        step();
        idle();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("midclr_initdone", {31'b0, InitDone}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_init("midclr_latency", 0);
        read4("midclr_words", {7'd127, 7'd80, 7'd81, 7'd0}, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
